// File: rtl/arb_pkg.sv
// Shared types and helpers for the registered round-robin / fixed-priority arbiter.
package arb_pkg;

    typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;

    // Pointer for the next round: one below the last winner, wrapping from 0 to n-1.
    function automatic int unsigned rr_ptr_next(input int unsigned cur, input int unsigned n);
        return (cur == 0) ? (n - 1) : (cur - 1);
    endfunction

endpackage

// File: rtl/pri_enc.sv
// Combinational priority encoder: reports the highest index whose req bit is at level ACT.
module pri_enc #(
    parameter int   IN  = 8,
    parameter int   OUT = $clog2(IN),
    parameter logic ACT = 1'b1
) (
    input  logic [IN-1:0]  req,
    output logic           valid,
    output logic [OUT-1:0] out
);

    always_comb begin
        valid = 1'b0;
        out   = '0;
        // Ascending scan so the last (highest) hit is what remains.
        for (int i = 0; i < IN; i++) begin
            if (req[i] == ACT) begin
                valid = 1'b1;
                out   = OUT'(i);
            end
        end
    end

endmodule

// File: rtl/rr_pri_arb.sv
// Registered round-robin / fixed-priority arbiter with a sticky grant held until ack.
module rr_pri_arb
    import arb_pkg::*;
#(
    parameter int   IN  = 8,
    parameter int   OUT = $clog2(IN),
    parameter logic ACT = 1'b1,
    parameter bit   RR  = 1'b1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [IN-1:0]  req,
    input  logic           ack,
    output logic           valid,
    output logic [OUT-1:0] out,
    output logic [IN-1:0]  grant_vec
);

    localparam logic [OUT-1:0] PTR_INIT = OUT'(IN - 1);

    arb_state_t     state, state_d;
    logic [OUT-1:0] ptr, ptr_d, out_d;
    logic           valid_d;

    logic [IN-1:0]  req_act, mask, req_masked;
    logic [OUT-1:0] ptr_upd, ptr_eff, winner;
    logic           pe_m_valid, pe_u_valid;
    logic [OUT-1:0] pe_m_out, pe_u_out;
    logic           accept;

    assign req_act = ACT ? req : ~req;
    assign accept  = (state == ARB_GRANT) && ack;
    assign ptr_upd = RR ? OUT'(rr_ptr_next(int'(unsigned'(out)), IN)) : PTR_INIT;

    // The winner loaded on an accepting edge already sees the post-ack pointer.
    assign ptr_eff = accept ? ptr_upd : ptr;

    always_comb begin
        mask = '0;
        for (int i = 0; i < IN; i++) begin
            mask[i] = (i <= int'(unsigned'(ptr_eff)));
        end
    end

    assign req_masked = req_act & mask;

    pri_enc #(.IN(IN), .OUT(OUT), .ACT(1'b1)) u_pe_masked (
        .req   (req_masked),
        .valid (pe_m_valid),
        .out   (pe_m_out)
    );

    pri_enc #(.IN(IN), .OUT(OUT), .ACT(1'b1)) u_pe_unmasked (
        .req   (req_act),
        .valid (pe_u_valid),
        .out   (pe_u_out)
    );

    assign winner = (RR && pe_m_valid) ? pe_m_out : pe_u_out;

    always_comb begin
        state_d = state;
        ptr_d   = ptr;
        out_d   = out;
        valid_d = valid;
        case (state)
            ARB_IDLE: begin
                if (pe_u_valid) begin
                    out_d   = winner;
                    valid_d = 1'b1;
                    state_d = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                if (ack) begin
                    ptr_d = ptr_upd;
                    if (pe_u_valid) begin
                        out_d = winner;
                    end else begin
                        out_d   = '0;
                        valid_d = 1'b0;
                        state_d = ARB_IDLE;
                    end
                end
            end
            default: begin
                state_d = ARB_IDLE;
                out_d   = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ARB_IDLE;
            ptr   <= PTR_INIT;
            out   <= '0;
            valid <= 1'b0;
        end else begin
            state <= state_d;
            ptr   <= ptr_d;
            out   <= out_d;
            valid <= valid_d;
        end
    end

    assign grant_vec = valid ? (IN'(1) << out) : '0;

endmodule

// File: tb/tb_rr_pri_arb.sv
// Directed and sweep bench for rr_pri_arb: round-robin, fixed-priority and active-low instances.
module tb_rr_pri_arb;

    localparam int IN  = 8;
    localparam int OUT = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // _a: RR=1 ACT=high, _f: RR=0 ACT=high, _l: RR=1 ACT=low
    logic           reset_a, ack_a, valid_a;
    logic [IN-1:0]  req_a, gv_a;
    logic [OUT-1:0] out_a;
    logic           reset_f, ack_f, valid_f;
    logic [IN-1:0]  req_f, gv_f;
    logic [OUT-1:0] out_f;
    logic           reset_l, ack_l, valid_l;
    logic [IN-1:0]  req_l, gv_l;
    logic [OUT-1:0] out_l;

    rr_pri_arb #(.IN(IN), .OUT(OUT), .ACT(1'b1), .RR(1'b1)) u_rr (
        .clk(clk), .reset(reset_a), .req(req_a), .ack(ack_a),
        .valid(valid_a), .out(out_a), .grant_vec(gv_a)
    );
    rr_pri_arb #(.IN(IN), .OUT(OUT), .ACT(1'b1), .RR(1'b0)) u_fp (
        .clk(clk), .reset(reset_f), .req(req_f), .ack(ack_f),
        .valid(valid_f), .out(out_f), .grant_vec(gv_f)
    );
    rr_pri_arb #(.IN(IN), .OUT(OUT), .ACT(1'b0), .RR(1'b1)) u_lo (
        .clk(clk), .reset(reset_l), .req(req_l), .ack(ack_l),
        .valid(valid_l), .out(out_l), .grant_vec(gv_l)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_grant(input string tag, input logic v, input logic [OUT-1:0] o,
                               input logic [IN-1:0] g, input int ev, input int eo);
        logic [IN-1:0] eg;
        eg = (ev != 0) ? (IN'(1) << eo) : '0;
        check({tag, ".valid"}, 32'(v), 32'(ev));
        check({tag, ".out"}, 32'(o), 32'(ev != 0 ? eo : 0));
        check({tag, ".gvec"}, 32'(g), 32'(eg));
    endtask

    // Behavioural reference for the round-robin, active-high instance.
    int m_valid, m_out, m_ptr;

    function automatic int rr_win(input logic [IN-1:0] r, input int p);
        for (int i = p; i >= 0; i--) if (r[i]) return i;
        for (int i = IN - 1; i >= 0; i--) if (r[i]) return i;
        return 0;
    endfunction

    task automatic model_step(input logic [IN-1:0] r, input logic a);
        if (m_valid == 0) begin
            if (r != 0) begin
                m_out   = rr_win(r, m_ptr);
                m_valid = 1;
            end
        end else if (a) begin
            m_ptr = (m_out == 0) ? IN - 1 : m_out - 1;
            if (r != 0) begin
                m_out = rr_win(r, m_ptr);
            end else begin
                m_valid = 0;
                m_out   = 0;
            end
        end
    endtask

    task automatic reset_rr();
        reset_a = 1'b1; req_a = '0; ack_a = 1'b0;
        tick();
        reset_a = 1'b0;
        m_valid = 0; m_out = 0; m_ptr = IN - 1;
    endtask

    initial begin
        int seq [6];
        seq = '{7, 5, 2, 7, 5, 2};
        reset_a = 1'b1; req_a = '0;   ack_a = 1'b0;
        reset_f = 1'b1; req_f = '0;   ack_f = 1'b0;
        reset_l = 1'b1; req_l = '1;   ack_l = 1'b0;
        tick();
        tick();

        // 1: reset then idle requests
        check_grant("t1_in_reset", valid_a, out_a, gv_a, 0, 0);
        reset_a = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_grant($sformatf("t1_idle%0d", i), valid_a, out_a, gv_a, 0, 0);
        end

        // 2: round-robin rotation with continuous ack
        reset_rr();
        req_a = 8'hA4; ack_a = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check_grant($sformatf("t2_rot%0d", i), valid_a, out_a, gv_a, 1, seq[i]);
        end

        // 3: sticky grant survives request withdrawal
        reset_rr();
        req_a = 8'h10; ack_a = 1'b0;
        tick();
        req_a = 8'h00;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_grant($sformatf("t3_hold%0d", i), valid_a, out_a, gv_a, 1, 4);
        end
        ack_a = 1'b1;
        tick();
        ack_a = 1'b0;
        check_grant("t3_release", valid_a, out_a, gv_a, 0, 0);

        // 4: fixed priority
        reset_f = 1'b0;
        req_f = 8'hFF; ack_f = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_grant($sformatf("t4_ff%0d", i), valid_f, out_f, gv_f, 1, 7);
        end
        req_f = 8'h03;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_grant($sformatf("t4_03_%0d", i), valid_f, out_f, gv_f, 1, 1);
        end

        // 5: active-low requests, pointer wraps from 0 to IN-1
        reset_l = 1'b0;
        req_l = 8'hFE; ack_l = 1'b0;
        tick();
        check_grant("t5_first", valid_l, out_l, gv_l, 1, 0);
        ack_l = 1'b1;
        tick();
        ack_l = 1'b0;
        check_grant("t5_again", valid_l, out_l, gv_l, 1, 0);
        check("t5_ptr", 32'(u_lo.ptr), 32'(7));

        // 6: reset mid-grant clears the grant and restores the pointer
        reset_rr();
        req_a = 8'h24; ack_a = 1'b0;
        tick();
        check_grant("t6_pre", valid_a, out_a, gv_a, 1, 5);
        ack_a = 1'b1;
        tick();
        check_grant("t6_next", valid_a, out_a, gv_a, 1, 2);
        reset_a = 1'b1;
        tick();
        check_grant("t6_reset", valid_a, out_a, gv_a, 0, 0);
        reset_a = 1'b0; ack_a = 1'b0; req_a = 8'h21;
        tick();
        check_grant("t6_after", valid_a, out_a, gv_a, 1, 5);

        // Exhaustive request sweep with random ack against the reference model
        reset_rr();
        for (int v = 0; v < (1 << IN); v++) begin
            req_a = IN'(v);
            ack_a = 1'($urandom_range(0, 1));
            model_step(req_a, ack_a);
            tick();
            check_grant($sformatf("sweep_%0d", v), valid_a, out_a, gv_a, m_valid, m_out);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
